// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants for the UART command scheduler: frame opcodes, pad byte,
// response codes, FSM state encoding and the trigger-mask decode helper.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

   localparam logic [7:0] OP_SET   = 8'h53;
   localparam logic [7:0] OP_TRIG  = 8'h5C;
   localparam logic [7:0] PAD_BYTE = 8'h00;
   localparam logic [7:0] RESP_ACK = 8'hA5;
   localparam logic [7:0] RESP_NAK = 8'h15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_PAD  = 3'd1,
      S_CH   = 3'd2,
      S_VAL  = 3'd3,
      T_MASK = 3'd4,
      EXEC   = 3'd5,
      RESP   = 3'd6
   } state_t;

   // A zero mask is shorthand for "all four channels".
   function automatic logic [3:0] trig_sel(input logic [7:0] mask);
      return (mask == 8'h00) ? 4'hF : mask[3:0];
   endfunction

endpackage

// File: rtl/uart_trig_pulse.sv
// -----------------------------------------------------------------------------
// uart_trig_pulse
// One trigger channel: a start strobe (re)loads a down-counter, and the pulse
// output is high while the counter is non-zero.
//   clk      : system clock
//   nrst     : asynchronous active-low reset
//   i_start  : one-cycle start strobe; restarts the full width if already busy
//   o_pulse  : trigger output, high for exactly PULSE_CYCLES cycles
// -----------------------------------------------------------------------------
module uart_trig_pulse #(
   parameter int PULSE_CYCLES = 12
) (
   input  logic clk,
   input  logic nrst,
   input  logic i_start,
   output logic o_pulse
);

   localparam int CW = $clog2(PULSE_CYCLES + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= CW'(PULSE_CYCLES);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_pulse = (r_cnt != '0);

endmodule

// File: rtl/uart_cmd_sched.sv
// -----------------------------------------------------------------------------
// uart_cmd_sched
// Parses SET (53 00 CH VAL) and TRIG (5C MASK) frames from a UART receiver,
// writes channel value registers, fires per-channel trigger pulses and returns
// an ACK (A5) or NAK (15) byte to the UART transmitter.
//   clk, nrst                 : clock, asynchronous active-low reset
//   rx_data, rx_valid         : received byte and its one-cycle strobe
//   tx_data, tx_valid,tx_ready: response byte handshake
//   trigout_ch0..3            : trigger pulses
//   vctrout_ch0..3            : channel value registers
//   overrun                   : sticky, set when a byte arrives in EXEC/RESP
//   o_dbg_state               : current FSM state, for observation
//
// Handshake: tx_valid is high for the whole RESP state and tx_data is held
// stable until a cycle with tx_valid && tx_ready; that cycle is the transfer
// and the FSM returns to IDLE on it. rx_valid has no back-pressure: bytes
// arriving while busy (EXEC/RESP) are dropped and flagged in overrun.
// -----------------------------------------------------------------------------
module uart_cmd_sched
   import uart_cmd_pkg::*;
#(
   parameter int TRIG_PULSE_CYCLES = 12,
   parameter int FRAME_TIMEOUT     = 5000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       trigout_ch0,
   output logic       trigout_ch1,
   output logic       trigout_ch2,
   output logic       trigout_ch3,
   output logic [7:0] vctrout_ch0,
   output logic [7:0] vctrout_ch1,
   output logic [7:0] vctrout_ch2,
   output logic [7:0] vctrout_ch3,
   output logic       overrun,
   output state_t     o_dbg_state
);

   localparam int TW = $clog2(FRAME_TIMEOUT + 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_bad;       // frame has failed a validity check
   logic          r_is_set;    // current frame is SET (else TRIG)
   logic [1:0]    r_ch;
   logic [7:0]    r_val;
   logic [7:0]    r_mask;
   logic [7:0]    r_tx_data;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_vctr [4];
   logic          r_overrun;

   logic          w_in_frame;
   logic          w_timeout;
   logic          w_tx_load;
   logic [7:0]    w_tx_byte;
   logic          w_wr_en;
   logic [3:0]    w_start;
   logic [3:0]    w_trig;

   assign w_in_frame = (r_state == S_PAD) || (r_state == S_CH) ||
                       (r_state == S_VAL) || (r_state == T_MASK);

   // A byte arriving on the last allowed cycle still wins over the timeout.
   assign w_timeout = w_in_frame && !rx_valid && (r_timer == TW'(FRAME_TIMEOUT - 1));

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // ---------------- FSM next state / control ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_tx_load   = 1'b0;
      w_tx_byte   = RESP_NAK;
      w_wr_en     = 1'b0;
      w_start     = 4'h0;
      unique case (r_state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == OP_SET)       w_state_nxt = S_PAD;
               else if (rx_data == OP_TRIG) w_state_nxt = T_MASK;
            end
         end
         S_PAD:  if (rx_valid) w_state_nxt = S_CH;
         S_CH:   if (rx_valid) w_state_nxt = S_VAL;
         S_VAL:  if (rx_valid) w_state_nxt = EXEC;
         T_MASK: if (rx_valid) w_state_nxt = EXEC;
         EXEC: begin
            w_tx_load   = 1'b1;
            w_tx_byte   = r_bad ? RESP_NAK : RESP_ACK;
            w_wr_en     = !r_bad && r_is_set;
            w_start     = (!r_bad && !r_is_set) ? trig_sel(r_mask) : 4'h0;
            w_state_nxt = RESP;
         end
         RESP:    if (tx_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (w_timeout) begin
         w_state_nxt = RESP;
         w_tx_load   = 1'b1;
         w_tx_byte   = RESP_NAK;
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_bad     <= 1'b0;
         r_is_set  <= 1'b0;
         r_ch      <= 2'd0;
         r_val     <= 8'h00;
         r_mask    <= 8'h00;
         r_tx_data <= 8'h00;
         r_timer   <= '0;
         r_overrun <= 1'b0;
         for (int i = 0; i < 4; i++) r_vctr[i] <= 8'h00;
      end else begin
         // Idle-gap counter: cleared by every accepted byte and outside frames.
         if (!w_in_frame || rx_valid) r_timer <= '0;
         else                         r_timer <= r_timer + 1'b1;

         unique case (r_state)
            IDLE: if (rx_valid) begin
               r_bad    <= 1'b0;
               r_is_set <= (rx_data == OP_SET);
            end
            S_PAD: if (rx_valid) r_bad <= r_bad | (rx_data != PAD_BYTE);
            S_CH: if (rx_valid) begin
               r_ch  <= rx_data[1:0];
               r_bad <= r_bad | (rx_data > 8'd3);
            end
            S_VAL: if (rx_valid) r_val <= rx_data;
            T_MASK: if (rx_valid) begin
               r_mask <= rx_data;
               r_bad  <= r_bad | (rx_data[7:4] != 4'h0);
            end
            default: ;
         endcase

         if (w_tx_load) r_tx_data <= w_tx_byte;
         if (w_wr_en)   r_vctr[r_ch] <= r_val;
         if (rx_valid && ((r_state == EXEC) || (r_state == RESP))) r_overrun <= 1'b1;
      end
   end

   // ---------------- trigger channels ----------------
   for (genvar g = 0; g < 4; g++) begin : g_trig
      uart_trig_pulse #(
         .PULSE_CYCLES(TRIG_PULSE_CYCLES)
      ) u_trig (
         .clk     (clk),
         .nrst    (nrst),
         .i_start (w_start[g]),
         .o_pulse (w_trig[g])
      );
   end

   assign tx_data     = r_tx_data;
   assign tx_valid    = (r_state == RESP);
   assign trigout_ch0 = w_trig[0];
   assign trigout_ch1 = w_trig[1];
   assign trigout_ch2 = w_trig[2];
   assign trigout_ch3 = w_trig[3];
   assign vctrout_ch0 = r_vctr[0];
   assign vctrout_ch1 = r_vctr[1];
   assign vctrout_ch2 = r_vctr[2];
   assign vctrout_ch3 = r_vctr[3];
   assign overrun     = r_overrun;
   assign o_dbg_state = r_state;

endmodule
